// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: op encoding, FSM states and widths shared by the multiply sequencer
package mul_seq_pkg;
  localparam int OP_W = 32;
  localparam int PROD_W = 64;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MADD = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one radix step, partial + (multiplicand << shift) * multiplier bits
// ports: partial/mcand/mbits/shift in, result out (purely combinational)
module mul_step import mul_seq_pkg::*; #(
  parameter int BITS = 1
) (
  input  logic [PROD_W-1:0] partial,
  input  logic [OP_W-1:0]   mcand,
  input  logic [BITS-1:0]   mbits,
  input  logic [5:0]        shift,
  output logic [PROD_W-1:0] result
);
  always_comb begin
    result = partial;
    for (int i = 0; i < BITS; i++)
      result = mbits[i] ? result + ({{(PROD_W-OP_W){1'b0}}, mcand} << (shift + 6'(i))) : result;
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add HI/LO multiplier with PC stall and MFHI/MFLO readout
// ports: clk, rst (async active-low), mul_op/in1/in2 in; out, busy, stall, done out
module mul_sequencer import mul_seq_pkg::*; #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      mul_op,
  input  logic [OP_W-1:0] in1,
  input  logic [OP_W-1:0] in2,
  output logic [OP_W-1:0] out,
  output logic            busy,
  output logic            stall,
  output logic            done
);
  localparam int N = OP_W / BITS_PER_CYCLE;
  state_t state, state_d;
  logic [4:0] cnt;
  logic [OP_W-1:0] mcand, mplier, hi, lo, a_mag, b_mag;
  logic sign, acc, is_mul, is_signed, is_acc;
  logic [PROD_W-1:0] partial, step_out, prod, hl_next;
  logic [5:0] shift;
  assign is_mul = mul_op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
  assign is_signed = mul_op inside {OP_MULT, OP_MADD};
  assign is_acc = mul_op inside {OP_MADD, OP_MADDU};
  assign a_mag = (is_signed && in1[OP_W-1]) ? -in1 : in1;
  assign b_mag = (is_signed && in2[OP_W-1]) ? -in2 : in2;
  assign busy = state != S_IDLE;
  assign stall = busy && mul_op != OP_NOP && mul_op != OP_RSV;
  assign out = mul_op == OP_MFHI ? hi : mul_op == OP_MFLO ? lo : '0;
  // counter runs N-1..0, so the step index (and thus the shift) counts up from 0
  assign shift = 6'((N - 1 - int'(cnt)) * BITS_PER_CYCLE);
  assign prod = sign ? -partial : partial;
  assign hl_next = acc ? prod + {hi, lo} : prod;
  mul_step #(.BITS(BITS_PER_CYCLE)) u_step (
    .partial(partial),
    .mcand(mcand),
    .mbits(mplier[BITS_PER_CYCLE-1:0]),
    .shift(shift),
    .result(step_out)
  );
  always_comb begin
    state_d = state;
    state_d = (state == S_IDLE && is_mul) ? S_RUN :
              (state == S_RUN && cnt == 0) ? S_FIX :
              (state == S_FIX) ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      sign <= 1'b0;
      acc <= 1'b0;
      partial <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= state == S_FIX;
      case (state)
        S_IDLE: if (is_mul) begin
          mcand <= a_mag;
          mplier <= b_mag;
          sign <= is_signed && (in1[OP_W-1] ^ in2[OP_W-1]);
          acc <= is_acc;
          partial <= '0;
          cnt <= 5'(N - 1);
        end
        S_RUN: begin
          partial <= step_out;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt != 0) cnt <= cnt - 5'd1;
        end
        S_FIX: {hi, lo} <= hl_next;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle sequencer for the core's HI/LO multiply resource. It replaces the single-cycle multiplier path. It accepts a `mul_op` from the instruction decoder, latches the operands from the register file and runs an iterative shift-add product over several cycles. It then commits the result to internal HI/LO registers. It raises `stall` to freeze the PC while a new multiply-class instruction meets an unfinished one. MFHI/MFLO results are driven on `out` toward the ALU `b` operand mux.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4. The RUN length is 32/BITS_PER_CYCLE cycles.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mul_op`  in  3  decoder multiply op; encoding in the package (NOP=0, MULT=1, MULTU=2, MADD=3, MADDU=4, MFHI=5, MFLO=6, 7 reserved and treated as NOP).
- `in1`  in  32  register file `rd_data1` (rs).
- `in2`  in  32  register file `rd_data2` (rt).
- `out`  out  32  HI for MFHI, LO for MFLO, otherwise 0. Combinational from the HI/LO registers.
- `busy`  out  1  a product is in flight (state RUN or FIX).
- `stall`  out  1  combinational: `busy` and `mul_op` is not NOP/reserved. The PC must hold and register writeback must be suppressed.
- `done`  out  1  single-cycle pulse in the cycle after HI/LO commit.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with MULT/MULTU/MADD/MADDU:
  - Latch magnitudes of `in1`/`in2`. For signed ops use the absolute value; 0x80000000 has magnitude 2^31.
  - Latch the product sign (signed ops: s1 XOR s2; unsigned: 0), the accumulate flag, and clear the 64-bit partial product.
  - Load the step counter with 32/BITS_PER_CYCLE − 1, then go to RUN.
- RUN:
  - Each cycle, add (multiplicand << shift) × the low BITS_PER_CYCLE bits of the multiplier into the partial product, then shift the multiplier right.
  - At counter 0, go to FIX; otherwise decrement.
- FIX:
  - Negate the 64-bit product if the sign flag is set.
  - If the accumulate flag is set, add {HI,LO}; the sum wraps mod 2^64.
  - Write {HI,LO} and return to IDLE.
- MFHI/MFLO in IDLE: `out` shows HI or LO in the same cycle; there is no state change.
- A multiply-class op arriving while busy is not accepted. `stall` stays high and the op is re-presented every cycle until IDLE, at which point it is accepted normally.
- MFHI/MFLO while busy also stalls. On release it reads the committed values.
- Reserved op 7 is ignored and never stalls.

## Timing
- Reset (asynchronous, `rst` low):
  - State IDLE; HI=LO=0; partial product and counter 0.
  - Outputs: `busy`=0, `done`=0, `stall`=0, `out`=0.
  - Reset mid-RUN/FIX aborts the operation with no HI/LO write.
- Latency (N = 32/BITS_PER_CYCLE):
  - Op accepted in cycle 0.
  - `busy`=1 in cycles 1..N+1 (RUN 1..N, FIX N+1).
  - HI/LO update at the end of cycle N+1.
  - `done`=1 and `busy`=0 in cycle N+2.
  - MFHI in cycle N+2 reads the new value without stall.
- Back-to-back: a new multiply can be accepted in cycle N+2, the same cycle `done` is high.
- `stall` is a pure function of the current state and `mul_op`; there is no registered stall.

## Structure
- Package `mul_seq_pkg`:
  - `mul_op` encoding constants.
  - State enum (IDLE/RUN/FIX).
  - Product width 64 and operand width 32 constants.
- Sub-module `mul_step`: combinational single radix step taking (partial, multiplicand, multiplier bits, shift) and producing the next partial. It is instantiated once in RUN.
- The FSM, counter, operand/sign latches and HI/LO live in `mul_sequencer`.

## Test plan
- MULT in1=0xFFFFFFFF, in2=0x00000002 (BITS_PER_CYCLE=1) → `done` in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU, same operands → HI=0x00000001, LO=0xFFFFFFFE. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- After MULTU 3×5 (HI=0, LO=15), MADD in1=0xFFFFFFFF, in2=1 → HI=0, LO=14. Then MADDU 0xFFFFFFFF×0xFFFFFFFF → {HI,LO} = 0xFFFFFFFE_00000001 + 14, wrapping mod 2^64.
- MFLO presented in cycle 5 of a run → `stall`=1 through cycle 33. In cycle 34 `stall`=0 and `out`=new LO. MFHI in IDLE with `mul_op` 7 in the next cycle → no stall, `out`=0.
- Reset asserted in cycle 10 of a MULT → `busy`/`done`/`stall` drop immediately and HI=LO=0. The next MULT 7×6 gives LO=42.
- BITS_PER_CYCLE=4, MULTU 0x12345678×0x9ABCDEF0 → `done` in cycle 10 and the product matches the 64-bit reference model.
